// File: rtl/barrier_release_sequencer.sv
// Buffers barrier-release events and hands released wavefronts to fetch one
// per handshake, lowest wfid first, while holding not-yet-handed-off wavefronts.
module barrier_release_sequencer #(
    parameter int WF_PER_CU = 40,
    parameter int WFID_W    = 6,
    parameter int QDEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rel_en,
    input  logic [WF_PER_CU-1:0] rel_bitmap,
    input  logic [31:0]          rel_pc,
    input  logic                 flush_en,
    input  logic [WFID_W-1:0]    flush_wfid,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [WFID_W-1:0]    out_wfid,
    output logic [31:0]          out_pc,
    output logic [WF_PER_CU-1:0] wf_hold,
    output logic                 busy,
    output logic                 overflow
);

    // state | meaning
    // IDLE  | active bitmap empty; nothing presented to fetch
    // DRAIN | active bitmap non-empty; lowest set wfid presented

    localparam int IDX_W = $clog2(QDEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WF_PER_CU-1:0]   act_bmp_q, act_bmp_d;
    logic [31:0]            act_pc_q, act_pc_d;
    logic [WF_PER_CU-1:0]   fifo_bmp_q [QDEPTH];
    logic [31:0]            fifo_pc_q  [QDEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic                   overflow_q;

    logic [IDX_W-1:0]       wr_idx, rd_idx;
    logic [PTR_W-1:0]       fifo_count;
    logic                   fifo_empty, fifo_full;
    logic [IDX_W-1:0]       slot_off [QDEPTH];
    logic [QDEPTH-1:0]      entry_valid;
    logic [WF_PER_CU-1:0]   flush_mask;
    logic [WF_PER_CU-1:0]   low_mask;
    logic [WF_PER_CU-1:0]   act_cleared;
    logic [WF_PER_CU-1:0]   head_bmp;
    logic [31:0]            head_pc;
    logic                   rel_valid, handshake;
    logic                   bypass, pop, push, drop;

    assign wr_idx     = wr_ptr_q[IDX_W-1:0];
    assign rd_idx     = rd_ptr_q[IDX_W-1:0];
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);

    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            slot_off[i]    = IDX_W'(i) - rd_idx;
            entry_valid[i] = ({1'b0, slot_off[i]} < fifo_count);
        end
    end

    // Out-of-range flush ids match no bit and are therefore ignored.
    always_comb begin
        flush_mask = '0;
        for (int i = 0; i < WF_PER_CU; i++) begin
            flush_mask[i] = flush_en && (32'(flush_wfid) == i);
        end
    end

    assign rel_valid   = rel_en && (|rel_bitmap);
    assign out_valid   = (state_q == DRAIN);
    assign handshake   = out_valid && out_ready;
    assign low_mask    = act_bmp_q & ((~act_bmp_q) + WF_PER_CU'(1));
    assign act_cleared = act_bmp_q & ~(handshake ? low_mask : '0) & ~flush_mask;
    assign head_bmp    = fifo_bmp_q[rd_idx] & ~flush_mask;
    assign head_pc     = fifo_pc_q[rd_idx];

    // Popping an entry emptied by flush discards it and parks in IDLE for a cycle.
    always_comb begin
        state_d   = state_q;
        act_bmp_d = act_cleared;
        act_pc_d  = act_pc_q;
        pop       = 1'b0;
        bypass    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fifo_empty) begin
                    if (rel_valid) begin
                        bypass    = 1'b1;
                        act_bmp_d = rel_bitmap;
                        act_pc_d  = rel_pc;
                        state_d   = DRAIN;
                    end
                end else begin
                    pop = 1'b1;
                    if (|head_bmp) begin
                        act_bmp_d = head_bmp;
                        act_pc_d  = head_pc;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (act_cleared == '0) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (|head_bmp) begin
                            act_bmp_d = head_bmp;
                            act_pc_d  = head_pc;
                        end else begin
                            act_pc_d = '0;
                            state_d  = IDLE;
                        end
                    end else begin
                        act_pc_d = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A pop at the same edge frees a slot, so a full FIFO can still accept.
    assign push = rel_valid && !bypass && (!fifo_full || pop);
    assign drop = rel_valid && !bypass && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            act_bmp_q  <= '0;
            act_pc_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                fifo_bmp_q[i] <= '0;
                fifo_pc_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            act_bmp_q <= act_bmp_d;
            act_pc_q  <= act_pc_d;
            for (int i = 0; i < QDEPTH; i++) begin
                fifo_bmp_q[i] <= fifo_bmp_q[i] & ~flush_mask;
            end
            if (push) begin
                fifo_bmp_q[wr_idx] <= rel_bitmap;
                fifo_pc_q[wr_idx]  <= rel_pc;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        out_wfid = '0;
        for (int i = WF_PER_CU - 1; i >= 0; i--) begin
            if (act_bmp_q[i]) begin
                out_wfid = WFID_W'(i);
            end
        end
    end

    always_comb begin
        wf_hold = act_bmp_q;
        for (int i = 0; i < QDEPTH; i++) begin
            if (entry_valid[i]) begin
                wf_hold = wf_hold | fifo_bmp_q[i];
            end
        end
    end

    assign out_pc   = act_pc_q;
    assign busy     = (state_q == DRAIN) || !fifo_empty;
    assign overflow = overflow_q;

endmodule
